// File: rtl/prog_mem_pkg.sv
// Shared types and limits for the program memory: FSM states, burst length width, wait-state bound.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_mem_pkg;

    localparam int LEN_W    = 2;
    localparam int MAX_WAIT = 7;
    localparam int WCNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Out-of-range wait-state settings saturate rather than wrap the 3-bit counter.
    function automatic logic [WCNT_W-1:0] clamp_wait(input int ws);
        if (ws > MAX_WAIT)
            return WCNT_W'(MAX_WAIT);
        else if (ws < 0)
            return '0;
        else
            return WCNT_W'(ws);
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Synchronous single-port storage, DATA_W x 2**ADDR_W, no reset on contents or read register.
// Latency: rdata valid one edge after re.
// Backpressure: none; rdata holds its value while re is low.
module prog_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem_q[addr] <= wdata;
        if (re)
            rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory with valid/ready request/response channels and WAIT_STATES read wait states; PROG_MEM_BURST_EN enables 1-4 beat bursts.
// Latency: read data valid WAIT_STATES+1 edges after acceptance; writes complete at the accepting edge.
// Backpressure: req_ready only in IDLE; rsp_data/rsp_last hold until rsp_ready.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = clamp_wait(WAIT_STATES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                last_q, last_d;
    logic                req_acc, rd_fire, rsp_hs, beat_last;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;

`ifdef PROG_MEM_BURST_EN
    logic [LEN_W-1:0]    beats_q, beats_d;
    assign beat_last = (beats_q == '0);
`else
    logic                unused_len;
    assign unused_len = ^req_len;
    assign beat_last  = 1'b1;
`endif

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign req_acc   = req_valid && req_ready;
    assign rd_fire   = (state_q == WAIT) && (wcnt_q == '0);
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign mem_addr  = req_ready ? req_addr : addr_q;

    // Array read register has no reset; gating by RESP gives the zero reset value.
    assign rsp_data  = rsp_valid ? mem_rdata : '0;
    assign rsp_last  = last_q;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (req_acc && req_we),
        .re    (rd_fire),
        .addr  (mem_addr),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
`ifdef PROG_MEM_BURST_EN
        beats_d = beats_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_acc && !req_we) begin
                    addr_d  = req_addr;
                    wcnt_d  = WAIT_LOAD;
                    state_d = WAIT;
`ifdef PROG_MEM_BURST_EN
                    beats_d = req_len;
`endif
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    last_d  = beat_last;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_hs) begin
`ifdef PROG_MEM_BURST_EN
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        beats_d = beats_q - LEN_W'(1);
                        wcnt_d  = WAIT_LOAD;
                        state_d = WAIT;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            last_q  <= 1'b0;
`ifdef PROG_MEM_BURST_EN
            beats_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
`ifdef PROG_MEM_BURST_EN
            beats_q <= beats_d;
`endif
        end
    end

endmodule
